// File: rtl/sandpile_grid_arbiter.sv
// sandpile_grid_arbiter: shares the single-port grid RAM between the VGA renderer and the sandpile engine
//
// The renderer always wins when it needs the port (vga_active & rd_valid). The engine is served
// during blanking, and also in unused active-area cycles when SANDPILE_ARB_STEAL_EN is defined.
//
// Build option:
//   SANDPILE_ARB_STEAL_EN  engine may use active-area cycles where rd_valid=0
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   vga_active, rd_valid       renderer in visible area / renderer address in bounds
//   rd_x, rd_y, rd_data        renderer cell address and returned cell value (1-cycle latency)
//   eng_req_valid/ready        engine request handshake
//   eng_we, eng_x, eng_y       engine write enable and cell address
//   eng_wdata                  engine write data
//   eng_rsp_valid/data         engine read response, 1 cycle after acceptance, no backpressure
//   clr_stats, eng_stall_cnt   stall counter clear / saturating stall counter
//   mem_en, mem_we, mem_addr   RAM control, address is {y, x}
//   mem_wdata, mem_rdata       RAM write data / read data (valid 1 cycle after a read)
module sandpile_grid_arbiter #(
    parameter int MAX_SIZE = 32,
    parameter int DATA_W   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vga_active,
    input  logic                          rd_valid,
    input  logic [$clog2(MAX_SIZE)-1:0]   rd_x,
    input  logic [$clog2(MAX_SIZE)-1:0]   rd_y,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          eng_req_valid,
    output logic                          eng_req_ready,
    input  logic                          eng_we,
    input  logic [$clog2(MAX_SIZE)-1:0]   eng_x,
    input  logic [$clog2(MAX_SIZE)-1:0]   eng_y,
    input  logic [DATA_W-1:0]             eng_wdata,
    output logic                          eng_rsp_valid,
    output logic [DATA_W-1:0]             eng_rsp_data,
    input  logic                          clr_stats,
    output logic [15:0]                   eng_stall_cnt,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [2*$clog2(MAX_SIZE)-1:0] mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);
    localparam int ADDR_W = $clog2(MAX_SIZE);

    typedef enum logic {ST_ENG, ST_VGA} state_t;

    state_t              state_q, state_d;
    logic                rst_done_q;
    logic                rnd_grant_q;
    logic [DATA_W-1:0]   rd_hold_q;
    logic                rsp_pend_q;
    logic [15:0]         stall_q, stall_d;
    logic                rnd_need, rnd_grant, eng_acc;

    assign rnd_need  = vga_active & rd_valid;
    // nothing reaches the RAM until the first clock after reset release
    assign rnd_grant = rst_done_q & rnd_need;
`ifdef SANDPILE_ARB_STEAL_EN
    assign eng_req_ready = rst_done_q & ~rnd_need;
`else
    assign eng_req_ready = rst_done_q & ~vga_active;
`endif
    assign eng_acc = eng_req_valid & eng_req_ready;

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_ENG && vga_active)
            state_d = ST_VGA;
        else if (state_q == ST_VGA && !vga_active)
            state_d = ST_ENG;
        // grants follow the live vga_active so the renderer is never a cycle late
        if (rnd_grant) begin
            mem_en   = 1'b1;
            mem_addr = {rd_y, rd_x};
        end else if (eng_acc) begin
            mem_en    = 1'b1;
            mem_we    = eng_we;
            mem_addr  = {eng_y, eng_x};
            mem_wdata = eng_wdata;
        end
    end

    assign stall_d = clr_stats ? 16'd0
                   : (eng_req_valid && !eng_req_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1
                   : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENG;
            rst_done_q  <= 1'b0;
            rnd_grant_q <= 1'b0;
            rd_hold_q   <= '0;
            rsp_pend_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= 1'b1;
            rnd_grant_q <= rnd_grant;
            if (rnd_grant_q)
                rd_hold_q <= mem_rdata;
            rsp_pend_q  <= eng_acc & ~eng_we;
            stall_q     <= stall_d;
        end
    end

    // renderer sees fresh data right after its grant and the held value through gaps
    assign rd_data       = rnd_grant_q ? mem_rdata : rd_hold_q;
    assign eng_rsp_valid = rsp_pend_q;
    assign eng_rsp_data  = rsp_pend_q ? mem_rdata : '0;
    assign eng_stall_cnt = stall_q;

    logic unused_addr_w;
    assign unused_addr_w = ^{ADDR_W[0]};
endmodule

// File: tb/tb_sandpile_grid_arbiter.sv
// tb_sandpile_grid_arbiter: directed self-checking bench for sandpile_grid_arbiter with a write-first RAM model
module tb_sandpile_grid_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_active, rd_valid;
    logic [4:0]  rd_x, rd_y, eng_x, eng_y;
    logic [2:0]  rd_data, eng_wdata, eng_rsp_data, mem_wdata, mem_rdata;
    logic        eng_req_valid, eng_req_ready, eng_we, eng_rsp_valid, clr_stats;
    logic [15:0] eng_stall_cnt;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [2:0]  ram [1024];
    int          vectors = 0;
    int          errors  = 0;

    sandpile_grid_arbiter dut (
        .clk(clk), .rst_n(rst_n), .vga_active(vga_active), .rd_valid(rd_valid),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_we(eng_we),
        .eng_x(eng_x), .eng_y(eng_y), .eng_wdata(eng_wdata),
        .eng_rsp_valid(eng_rsp_valid), .eng_rsp_data(eng_rsp_data),
        .clr_stats(clr_stats), .eng_stall_cnt(eng_stall_cnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic eng_write(input logic [4:0] x, input logic [4:0] y, input logic [2:0] d);
        eng_req_valid = 1'b1; eng_we = 1'b1; eng_x = x; eng_y = y; eng_wdata = d;
        @(negedge clk);
        eng_req_valid = 1'b0; eng_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vga_active = 1'b0; rd_valid = 1'b0; rd_x = '0; rd_y = '0;
        eng_req_valid = 1'b0; eng_we = 1'b0; eng_x = '0; eng_y = '0; eng_wdata = '0; clr_stats = 1'b0;
        #1;
        vectors++;
        if ({rd_data, eng_rsp_valid, eng_rsp_data, eng_stall_cnt, mem_en, mem_we} !== 25'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {rd_data, eng_rsp_valid, eng_rsp_data, eng_stall_cnt, mem_en, mem_we});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (mem_en !== 1'b0 || eng_req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_first_cycle: mem_en=%b ready=%b want 0 0", mem_en, eng_req_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (eng_req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b want 1", eng_req_ready);
        end
    endtask

    task automatic test_render;
        @(negedge clk);
        eng_write(5'd5, 5'd7, 3'd3);
        vga_active = 1'b1; rd_valid = 1'b1; rd_x = 5'd5; rd_y = 5'd7; eng_req_valid = 1'b1;
        #1;
        vectors++;
        if (mem_addr !== 10'h0E5 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL render_addr: addr=%h en=%b we=%b want 0e5 1 0", mem_addr, mem_en, mem_we);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) #1;
            vectors++;
            if (eng_req_ready !== 1'b0) begin
                errors++; $display("FAIL render_ready cycle %0d: got %b want 0", i, eng_req_ready);
            end
            @(negedge clk);
            if (i == 0) begin
                vectors++;
                if (rd_data !== 3'd3) begin
                    errors++; $display("FAIL render_data: got %0d want 3", rd_data);
                end
            end
        end
        vectors++;
        if (eng_stall_cnt !== 16'd10) begin
            errors++; $display("FAIL stall_count_10: got %0d want 10", eng_stall_cnt);
        end
        eng_req_valid = 1'b0;
    endtask

    task automatic test_write_read;
        vga_active = 1'b0; rd_valid = 1'b0;
        eng_req_valid = 1'b1; eng_we = 1'b1; eng_x = 5'd3; eng_y = 5'd4; eng_wdata = 3'd2;
        #1;
        vectors++;
        if (eng_req_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h083 || mem_wdata !== 3'd2) begin
            errors++; $display("FAIL eng_write: ready=%b we=%b addr=%h wd=%0d want 1 1 083 2", eng_req_ready, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        eng_we = 1'b0;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || eng_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL eng_read_issue: en=%b we=%b rsp=%b want 1 0 0", mem_en, mem_we, eng_rsp_valid);
        end
        @(negedge clk);
        eng_req_valid = 1'b0;
        #1;
        vectors++;
        if (eng_rsp_valid !== 1'b1 || eng_rsp_data !== 3'd2) begin
            errors++; $display("FAIL eng_read_rsp: valid=%b data=%0d want 1 2", eng_rsp_valid, eng_rsp_data);
        end
        @(negedge clk);
        vectors++;
        if (eng_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL eng_rsp_single: got %b want 0", eng_rsp_valid);
        end
    endtask

    task automatic test_read_into_active;
        eng_write(5'd6, 5'd2, 3'd5);
        eng_req_valid = 1'b1; eng_we = 1'b0; eng_x = 5'd6; eng_y = 5'd2;
        #1;
        vectors++;
        if (eng_req_ready !== 1'b1) begin
            errors++; $display("FAIL last_blank_ready: got %b want 1", eng_req_ready);
        end
        @(negedge clk);
        eng_req_valid = 1'b0; vga_active = 1'b1; rd_valid = 1'b1; rd_x = 5'd5; rd_y = 5'd7;
        #1;
        vectors++;
        if (eng_rsp_valid !== 1'b1 || eng_rsp_data !== 3'd5 || mem_addr !== 10'h0E5 || mem_en !== 1'b1) begin
            errors++; $display("FAIL rsp_at_active: valid=%b data=%0d addr=%h en=%b want 1 5 0e5 1", eng_rsp_valid, eng_rsp_data, mem_addr, mem_en);
        end
        @(negedge clk);
        vectors++;
        if (rd_data !== 3'd3 || eng_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL render_after_rsp: rd_data=%0d rsp=%b want 3 0", rd_data, eng_rsp_valid);
        end
    endtask

    task automatic test_gap;
        int accepted = 0;
        rd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            eng_req_valid = 1'b1; eng_we = 1'b1; eng_x = 5'(i); eng_y = 5'd10; eng_wdata = 3'(i);
            #1;
            if (eng_req_ready) accepted++;
`ifndef SANDPILE_ARB_STEAL_EN
            vectors++;
            if (eng_req_ready !== 1'b0) begin
                errors++; $display("FAIL gap_ready cycle %0d: got %b want 0", i, eng_req_ready);
            end
`endif
            vectors++;
            if (rd_data !== 3'd3) begin
                errors++; $display("FAIL gap_hold cycle %0d: got %0d want 3", i, rd_data);
            end
            @(negedge clk);
        end
        eng_req_valid = 1'b0; eng_we = 1'b0;
        #1;
        vectors++;
`ifdef SANDPILE_ARB_STEAL_EN
        if (accepted !== 8 || rd_data !== 3'd3) begin
            errors++; $display("FAIL gap_steal: accepted=%0d rd_data=%0d want 8 3", accepted, rd_data);
        end
`else
        if (accepted !== 0 || rd_data !== 3'd3) begin
            errors++; $display("FAIL gap_nosteal: accepted=%0d rd_data=%0d want 0 3", accepted, rd_data);
        end
`endif
        rd_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (rd_data !== 3'd3) begin
            errors++; $display("FAIL gap_resume: got %0d want 3", rd_data);
        end
    endtask

    task automatic test_reset_mid;
        vga_active = 1'b0; rd_valid = 1'b0;
        eng_req_valid = 1'b1; eng_we = 1'b0; eng_x = 5'd3; eng_y = 5'd4;
        @(posedge clk);
        #1;
        vectors++;
        if (eng_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pending: got %b want 1", eng_rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rd_data, eng_rsp_valid, eng_rsp_data, eng_stall_cnt, mem_en, mem_we, eng_req_ready, mem_addr, mem_wdata} !== 39'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 0", {rd_data, eng_rsp_valid, eng_rsp_data, eng_stall_cnt, mem_en, mem_we, eng_req_ready, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1; eng_req_valid = 1'b0; vga_active = 1'b1; rd_valid = 1'b1; rd_x = 5'd5; rd_y = 5'd7;
        #1;
        vectors++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL mid_release_first: mem_en=%b want 0", mem_en);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_addr !== 10'h0E5) begin
            errors++; $display("FAIL mid_resume: en=%b addr=%h want 1 0e5", mem_en, mem_addr);
        end
        @(negedge clk);
        vectors++;
        if (rd_data !== 3'd3) begin
            errors++; $display("FAIL mid_resume_data: got %0d want 3", rd_data);
        end
    endtask

    task automatic test_saturation;
        eng_req_valid = 1'b1; eng_we = 1'b0;
        repeat (70000) @(negedge clk);
        vectors++;
        if (eng_stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL stall_saturate: got %h want ffff", eng_stall_cnt);
        end
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        #1;
        vectors++;
        if (eng_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL stall_clear: got %h want 0", eng_stall_cnt);
        end
        @(negedge clk);
        vectors++;
        if (eng_stall_cnt !== 16'd1) begin
            errors++; $display("FAIL stall_after_clear: got %h want 1", eng_stall_cnt);
        end
        eng_req_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_render;
        test_write_read;
        test_read_into_active;
        test_gap;
        test_reset_mid;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sandpile_grid_arbiter.md
Name: sandpile_grid_arbiter

Overview:
- Shares the single-port synchronous grid RAM between two requesters: the VGA renderer (hard real-time reads) and the sandpile update engine (read/write requests over a valid/ready handshake).
- Sits between the renderer, the toppling engine and the grid RAM.
- The renderer always wins when it needs the port. The engine gets the port during blanking and, optionally, during unused active-area cycles.

Parameters:
- MAX_SIZE, 32, maximum grid dimension. ADDR_W = $clog2(MAX_SIZE) is a derived localparam.
- DATA_W, 3, bits per grid cell.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- vga_active  in  1  pixel pipeline is in the visible area
- rd_valid  in  1  renderer address is in bounds (renderer's registered in-bounds flag)
- rd_x, rd_y  in  ADDR_W each  renderer cell address, registered by the renderer
- rd_data  out  DATA_W  cell value returned to the renderer
- eng_req_valid  in  1  engine request
- eng_req_ready  out  1  engine request accepted this cycle
- eng_we  in  1  1 = write, 0 = read
- eng_x, eng_y  in  ADDR_W each  engine cell address
- eng_wdata  in  DATA_W  engine write data
- eng_rsp_valid  out  1  engine read data valid
- eng_rsp_data  out  DATA_W  engine read data
- clr_stats  in  1  single-cycle clear of the stall counter
- eng_stall_cnt  out  16  saturating count of engine stall cycles
- mem_en, mem_we  out  1 each  RAM enable and write enable
- mem_addr  out  2*ADDR_W  RAM address, {y, x}
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset values: rd_data=0, eng_rsp_valid=0, eng_rsp_data=0, eng_stall_cnt=0.
- Reset flag: internal rst_done flop clears asynchronously on reset and sets on the first clk after rst_n rises. While rst_done=0: mem_en=0, mem_we=0, eng_req_ready=0.
- State machine, two states:
  - ST_ENG (reset state): go to ST_VGA when vga_active=1.
  - ST_VGA: go back to ST_ENG when vga_active=0.
  - Transitions take effect on the next edge. Grant decisions use the live vga_active input, so the renderer is never late.
- Renderer need: rnd_need = vga_active & rd_valid.
  - When rnd_need=1: mem_en=1, mem_we=0, mem_addr={rd_y, rd_x}, eng_req_ready=0.
- Engine grant (base build): eng_req_ready = rst_done & ~vga_active.
  - Any accepted transfer (valid & ready) drives mem_en=1, mem_we=eng_we, mem_addr={eng_y, eng_x}, mem_wdata=eng_wdata.
  - Otherwise mem_en=0.
- mem_* outputs are combinational from the grant mux; no added request latency.
- Renderer read path:
  - rnd_grant_d = registered rnd_need.
  - rd_data = mem_rdata when rnd_grant_d=1, else rd_hold.
  - rd_hold is a register loaded with mem_rdata whenever rnd_grant_d=1.
  - Renderer data therefore arrives exactly 1 cycle after its address, and is held stable through gaps.
- Engine read path:
  - An accepted read at cycle t gives eng_rsp_valid=1 and eng_rsp_data=mem_rdata at t+1, for one cycle.
  - This holds even if vga_active rises at t+1.
  - The engine has no response backpressure; it must sink every response.
  - Writes produce no response. Back-to-back accepted reads give back-to-back responses.
- Ordering: an engine write at t followed by a read of the same cell at t+1 returns the new value (RAM is write-first, single port).
- Stall counter:
  - Increments each cycle eng_req_valid=1 and eng_req_ready=0, saturating at 16'hFFFF.
  - clr_stats=1 forces 0 on the next edge and wins over a simultaneous increment.
- Reset mid-operation: a pending eng_rsp_valid is dropped; rd_hold clears to 0.
- Engine addresses at or beyond MAX_SIZE cannot be expressed at ADDR_W width. The engine is responsible for staying within grid_size.

Optional Feature:
- Macro: SANDPILE_ARB_STEAL_EN.
- Defined: eng_req_ready = rst_done & ~rnd_need. The engine also steals active-area cycles where rd_valid=0 (side borders, out-of-grid pixels).
- Undefined: base rule only; the engine is served only while vga_active=0.
- In both builds the renderer is never denied a cycle when rnd_need=1.

Test Plan:
- Reset, then vga_active=1, rd_valid=1, rd_x=5, rd_y=7, RAM cell {7,5}=3 -> mem_addr=0x0E5, rd_data=3 one cycle later; eng_req_ready=0 throughout; eng_stall_cnt counts 10 after 10 cycles of eng_req_valid=1.
- vga_active=0; engine writes 2 to (3,4), then reads (3,4) next cycle -> mem_we pulses 1 then 0; eng_rsp_valid=1 with eng_rsp_data=2 two cycles after the write.
- Engine read accepted on the last blanking cycle, vga_active=1 next cycle -> eng_rsp_valid=1 with correct data the same cycle the renderer is granted; renderer data unaffected.
- rd_valid=0 for 8 cycles in the active area: without STEAL_EN -> eng_req_ready=0 and rd_data holds its last value. With STEAL_EN -> 8 engine transfers accepted, rd_data still held.
- Assert rst_n=0 mid-burst with eng_rsp_valid pending -> all outputs 0 immediately; after release mem_en=0 for the first cycle, then normal service resumes.
- eng_stall_cnt preloaded near saturation by 70000 stall cycles -> holds 0xFFFF; clr_stats pulsed together with a stall -> reads 0.
